// File: rtl/adc_uart_reporter_if.sv
// ============================================================================
// Module      : adc_uart_reporter_if
// Description : Byte-stream valid/ready bus between the ADC reporter and the
//               UART TX byte engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adc_uart_reporter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  // Byte producer (reporter) side
  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  // Byte consumer (UART TX) side
  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

`default_nettype wire

// File: rtl/adc_uart_reporter.sv
// ============================================================================
// Module      : adc_uart_reporter
// Description : Averages 2^AVG_LOG2 ADC samples per channel and, on every
//               report tick, streams a framed, checksummed packet of the
//               enabled channels to the UART TX over a valid/ready bus.
//               Frame: HDR, mask, [seq hi, seq lo], {[hi], lo} per enabled
//               channel, CSUM (8-bit sum of all bytes after HDR).
//               Optional macro ADC_UART_SEQ_EN adds a 16-bit frame sequence
//               number after the mask byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_uart_reporter #(
  parameter int         CH_NUM   = 8,
  parameter int         DATA_W   = 8,
  parameter int         AVG_LOG2 = 0,
  parameter int         TICK_DIV = 25_000_000,
  parameter logic [7:0] HDR_BYTE = 8'hA5
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     sample_valid,
  input  wire logic [CH_NUM*DATA_W-1:0] sample_data,
  input  wire logic [CH_NUM-1:0]        ch_mask,
  adc_uart_reporter_if.master           tx_if,
  output logic                          frame_busy,
  output logic                          overrun
);

  localparam int         ACC_W  = DATA_W + AVG_LOG2;
  localparam int         CNT_W  = AVG_LOG2 + 1;
  localparam int         AVG_N  = 1 << AVG_LOG2;
  localparam int         TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam bit         HAS_HI = (DATA_W > 8);
  // Channel index value meaning "no further enabled channel"
  localparam logic [3:0] CH_NONE = 4'(CH_NUM);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_MASK    = 3'd2,
    S_SEQ_HI  = 3'd3,
    S_SEQ_LO  = 3'd4,
    S_DATA_HI = 3'd5,
    S_DATA_LO = 3'd6,
    S_CSUM    = 3'd7
  } state_t;

  // Lowest enabled channel with index >= from, or CH_NONE
  function automatic logic [3:0] f_next_ch(input logic [CH_NUM-1:0] mask, input int from);
    logic [3:0] res;
    res = CH_NONE;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (i >= from && mask[i]) res = 4'(i);
    end
    return res;
  endfunction

  // ---------------------------------------------------------------- averaging
  logic [ACC_W-1:0]  r_acc  [CH_NUM];
  logic [DATA_W-1:0] r_snap [CH_NUM];
  logic [ACC_W-1:0]  w_sum  [CH_NUM];
  logic [CNT_W-1:0]  r_avg_cnt;
  logic              r_snap_valid;
  logic              w_avg_done;

  assign w_avg_done = (r_avg_cnt == CNT_W'(AVG_N - 1));

  // Running sum including the sample currently presented
  always_comb begin
    for (int k = 0; k < CH_NUM; k++) begin
      w_sum[k] = r_acc[k] + ACC_W'(sample_data[k*DATA_W +: DATA_W]);
    end
  end

  // Accumulate samples; on the last sample of a block publish the truncated mean
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CH_NUM; k++) begin
        r_acc[k]  <= '0;
        r_snap[k] <= '0;
      end
      r_avg_cnt    <= '0;
      r_snap_valid <= 1'b0;
    end else if (sample_valid) begin
      if (w_avg_done) begin
        for (int k = 0; k < CH_NUM; k++) begin
          r_snap[k] <= w_sum[k][ACC_W-1:AVG_LOG2];
          r_acc[k]  <= '0;
        end
        r_avg_cnt    <= '0;
        r_snap_valid <= 1'b1;
      end else begin
        for (int k = 0; k < CH_NUM; k++) begin
          r_acc[k] <= w_sum[k];
        end
        r_avg_cnt <= r_avg_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------- report tick
  logic [TICK_W-1:0] r_tick_cnt;
  logic              w_tick;

  assign w_tick = (r_tick_cnt == TICK_W'(TICK_DIV - 1));

  // Free-running divider, tick is the single wrap cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else r_tick_cnt <= r_tick_cnt + TICK_W'(1);
  end

  // ---------------------------------------------------------------- framer
  state_t            r_state, w_state_next;
  logic [3:0]        r_ch, w_ch_next;
  logic [DATA_W-1:0] r_frame_data [CH_NUM];
  logic [CH_NUM-1:0] r_frame_mask;
  logic [7:0]        r_csum;
  logic [7:0]        w_tx_data;
  logic              w_busy, w_hs, w_start;
  logic [3:0]        w_first_ch, w_after_ch;
  state_t            w_first_state, w_after_state;
  logic [DATA_W-1:0] w_cur;
  logic [15:0]       w_cur_ext;
`ifdef ADC_UART_SEQ_EN
  logic [15:0]       r_seq;
`endif

  assign w_busy  = (r_state != S_IDLE);
  assign w_hs    = w_busy & tx_if.tx_ready;
  // The frame buffer is loaded from the registered snapshot, so a sample
  // completing in the tick cycle is not part of this frame.
  assign w_start = w_tick & ~w_busy & r_snap_valid;

  assign w_first_ch    = f_next_ch(r_frame_mask, 0);
  assign w_after_ch    = f_next_ch(r_frame_mask, int'(r_ch) + 1);
  assign w_first_state = (w_first_ch == CH_NONE) ? S_CSUM : (HAS_HI ? S_DATA_HI : S_DATA_LO);
  assign w_after_state = (w_after_ch == CH_NONE) ? S_CSUM : (HAS_HI ? S_DATA_HI : S_DATA_LO);

  // Select the buffered sample of the channel being sent
  always_comb begin
    w_cur = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (r_ch == 4'(k)) w_cur = r_frame_data[k];
    end
  end

  assign w_cur_ext = 16'(w_cur);

  // FSM state and channel pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
    end else begin
      r_state <= w_state_next;
      r_ch    <= w_ch_next;
    end
  end

  // Next-state decode and the byte presented in each state
  always_comb begin
    w_state_next = r_state;
    w_ch_next    = r_ch;
    w_tx_data    = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_next = S_HDR;
          w_ch_next    = '0;
        end
      end
      S_HDR: begin
        w_tx_data = HDR_BYTE;
        if (w_hs) w_state_next = S_MASK;
      end
      S_MASK: begin
        w_tx_data = 8'(r_frame_mask);
        if (w_hs) begin
`ifdef ADC_UART_SEQ_EN
          w_state_next = S_SEQ_HI;
`else
          w_state_next = w_first_state;
          w_ch_next    = w_first_ch;
`endif
        end
      end
`ifdef ADC_UART_SEQ_EN
      S_SEQ_HI: begin
        w_tx_data = r_seq[15:8];
        if (w_hs) w_state_next = S_SEQ_LO;
      end
      S_SEQ_LO: begin
        w_tx_data = r_seq[7:0];
        if (w_hs) begin
          w_state_next = w_first_state;
          w_ch_next    = w_first_ch;
        end
      end
`endif
      S_DATA_HI: begin
        w_tx_data = w_cur_ext[15:8];
        if (w_hs) w_state_next = S_DATA_LO;
      end
      S_DATA_LO: begin
        w_tx_data = w_cur_ext[7:0];
        if (w_hs) begin
          w_state_next = w_after_state;
          w_ch_next    = w_after_ch;
        end
      end
      S_CSUM: begin
        w_tx_data = r_csum;
        if (w_hs) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Frame buffer capture at frame start and running checksum of sent bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CH_NUM; k++) r_frame_data[k] <= '0;
      r_frame_mask <= '0;
      r_csum       <= '0;
    end else if (w_start) begin
      for (int k = 0; k < CH_NUM; k++) r_frame_data[k] <= r_snap[k];
      r_frame_mask <= ch_mask;
      r_csum       <= '0;
    end else if (w_hs && r_state != S_HDR && r_state != S_CSUM) begin
      r_csum <= r_csum + w_tx_data;
    end
  end

  // Sticky overrun: a tick landed while a frame was still going out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun <= 1'b0;
    else if (w_tick && w_busy) overrun <= 1'b1;
  end

`ifdef ADC_UART_SEQ_EN
  // Frame sequence number advances once per completed frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_seq <= '0;
    else if (w_hs && r_state == S_CSUM) r_seq <= r_seq + 16'd1;
  end
`endif

  assign tx_if.tx_data  = w_tx_data;
  assign tx_if.tx_valid = w_busy;
  assign frame_busy     = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_adc_uart_reporter.sv
// ============================================================================
// Module      : tb_adc_uart_reporter
// Description : Directed bench for adc_uart_reporter. DUT A: 8 ch, 8 bit, no
//               averaging. DUT B: 2 ch, 10 bit, 4-sample averaging.
//               Honours ADC_UART_SEQ_EN when building expected frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_uart_reporter;

  typedef logic [7:0] byte_q_t [$];

`ifdef ADC_UART_SEQ_EN
  localparam bit SEQ_ON = 1'b1;
`else
  localparam bit SEQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sv_a = 1'b0, sv_b = 1'b0;
  logic [63:0] sd_a = '0;
  logic [19:0] sd_b = '0;
  logic [7:0]  mask_a = 8'h05;
  logic [1:0]  mask_b = 2'b01;
  wire logic   fb_a, fb_b, ov_a, ov_b;

  int n_vec = 0;
  int n_err = 0;
  byte_q_t q_a, q_b;

  adc_uart_reporter_if if_a ();
  adc_uart_reporter_if if_b ();

  adc_uart_reporter #(
    .CH_NUM(8), .DATA_W(8), .AVG_LOG2(0), .TICK_DIV(200), .HDR_BYTE(8'hA5)
  ) u_dut_a (
    .clk(clk), .rst(rst), .sample_valid(sv_a), .sample_data(sd_a),
    .ch_mask(mask_a), .tx_if(if_a), .frame_busy(fb_a), .overrun(ov_a)
  );

  adc_uart_reporter #(
    .CH_NUM(2), .DATA_W(10), .AVG_LOG2(2), .TICK_DIV(100), .HDR_BYTE(8'hA5)
  ) u_dut_b (
    .clk(clk), .rst(rst), .sample_valid(sv_b), .sample_data(sd_b),
    .ch_mask(mask_b), .tx_if(if_b), .frame_busy(fb_b), .overrun(ov_b)
  );

  always #5 clk = ~clk;

  // Record every accepted byte, sampled mid-cycle before the accepting edge
  always @(negedge clk) begin
    if (!rst && if_a.tx_valid && if_a.tx_ready) q_a.push_back(if_a.tx_data);
    if (!rst && if_b.tx_valid && if_b.tx_ready) q_b.push_back(if_b.tx_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_busy(input int which, input logic val, input int limit, input string tag);
    int n;
    n = 0;
    while (((which == 0) ? fb_a : fb_b) !== val && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 32'((which == 0) ? fb_a : fb_b), 32'(val));
  endtask

  task automatic chk_frame(input int which, input byte_q_t exp, input string tag);
    byte_q_t got;
    got = (which == 0) ? q_a : q_b;
    chk({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      chk($sformatf("%s_b%0d", tag, i),
          (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
    end
  endtask

  function automatic byte_q_t with_csum(input byte_q_t q);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 1; i < q.size(); i++) s = s + q[i];
    q.push_back(s);
    return q;
  endfunction

  // DUT A frame: mask 0x05, ch0 = 0x12, ch2 = 0x34
  function automatic byte_q_t exp_a(input logic [15:0] seq);
    byte_q_t q;
    q.push_back(8'hA5); q.push_back(8'h05);
    if (SEQ_ON) begin q.push_back(seq[15:8]); q.push_back(seq[7:0]); end
    q.push_back(8'h12); q.push_back(8'h34);
    return with_csum(q);
  endfunction

  // DUT B frame: mask 0x01, ch0 = d as hi/lo bytes
  function automatic byte_q_t exp_b(input logic [15:0] seq, input logic [9:0] d);
    byte_q_t q;
    q.push_back(8'hA5); q.push_back(8'h01);
    if (SEQ_ON) begin q.push_back(seq[15:8]); q.push_back(seq[7:0]); end
    q.push_back({6'b0, d[9:8]}); q.push_back(d[7:0]);
    return with_csum(q);
  endfunction

  task automatic feed_a();
    sd_a = 64'h7777_7777_7734_7712;
    sv_a = 1'b1;
    @(posedge clk); #1;
    sv_a = 1'b0;
  endtask

  task automatic feed_b(input logic [9:0] d);
    sd_b = {10'h155, d};
    sv_b = 1'b1;
    @(posedge clk); #1;
    sv_b = 1'b0;
  endtask

  initial begin
    if_a.tx_ready = 1'b1;
    if_b.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_a", 32'(if_a.tx_valid), 32'h0);
    chk("rst_data_a",  32'(if_a.tx_data),  32'h0);
    chk("rst_busy_a",  32'(fb_a),          32'h0);
    chk("rst_ovr_a",   32'(ov_a),          32'h0);
    chk("rst_valid_b", 32'(if_b.tx_valid), 32'h0);
    rst = 1'b0;

    // Averaging: three samples only, first tick must not start a frame
    feed_b(10'd10); feed_b(10'd11); feed_b(10'd12);
    repeat (150) @(posedge clk);
    #1;
    chk("b_noframe_len",  32'(q_b.size()), 32'h0);
    chk("b_noframe_busy", 32'(fb_b),       32'h0);
    // Fourth sample completes the block: mean of 10..13 truncates to 11
    feed_b(10'd13);
    wait_busy(1, 1'b1, 200, "b_f1_start");
    wait_busy(1, 1'b0, 50,  "b_f1_end");
    chk_frame(1, exp_b(16'd0, 10'h00B), "b_avg");
    // Full-scale 10-bit value split into hi/lo bytes
    q_b.delete();
    repeat (4) feed_b(10'h3FF);
    wait_busy(1, 1'b1, 200, "b_f2_start");
    wait_busy(1, 1'b0, 50,  "b_f2_end");
    chk_frame(1, exp_b(16'd1, 10'h3FF), "b_w10");

    // Basic frame on DUT A
    feed_a();
    wait_busy(0, 1'b1, 300, "a_f1_start");
    wait_busy(0, 1'b0, 50,  "a_f1_end");
    chk_frame(0, exp_a(16'd0), "a_basic");

    // Backpressure: stall on the MASK byte for five cycles
    q_a.delete();
    if_a.tx_ready = 1'b0;
    wait_busy(0, 1'b1, 300, "a_bp_start");
    chk("a_bp_hdr", 32'(if_a.tx_data), 32'hA5);
    if_a.tx_ready = 1'b1;
    @(posedge clk); #1;
    if_a.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("a_bp_valid%0d", i), 32'(if_a.tx_valid), 32'h1);
      chk($sformatf("a_bp_data%0d", i),  32'(if_a.tx_data),  32'h05);
    end
    if_a.tx_ready = 1'b1;
    wait_busy(0, 1'b0, 50, "a_bp_end");
    chk_frame(0, exp_a(16'd1), "a_bp");

    // Overrun: hold ready low across the next tick
    q_a.delete();
    if_a.tx_ready = 1'b0;
    wait_busy(0, 1'b1, 300, "a_ov_start");
    chk("a_ov_before", 32'(ov_a), 32'h0);
    repeat (250) @(posedge clk);
    #1;
    chk("a_ov_set",  32'(ov_a),          32'h1);
    chk("a_ov_hold", 32'(if_a.tx_data),  32'hA5);
    if_a.tx_ready = 1'b1;
    wait_busy(0, 1'b0, 50, "a_ov_end");
    chk_frame(0, exp_a(16'd2), "a_ov");
    chk("a_ov_sticky1", 32'(ov_a), 32'h1);
    q_a.delete();
    wait_busy(0, 1'b1, 300, "a_nx_start");
    wait_busy(0, 1'b0, 50,  "a_nx_end");
    chk_frame(0, exp_a(16'd3), "a_next");
    chk("a_ov_sticky2", 32'(ov_a), 32'h1);

    // Reset while the third byte is on the bus
    q_a.delete();
    wait_busy(0, 1'b1, 300, "a_rs_start");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("a_rs_valid", 32'(if_a.tx_valid), 32'h0);
    chk("a_rs_ovr",   32'(ov_a),          32'h0);
    chk("a_rs_busy",  32'(fb_a),          32'h0);
    chk("a_rs_sent",  32'(q_a.size()),    32'h2);
    @(posedge clk); #1;
    rst = 1'b0;
    q_a.delete();
    feed_a();
    wait_busy(0, 1'b1, 300, "a_pr_start");
    wait_busy(0, 1'b0, 50,  "a_pr_end");
    chk_frame(0, exp_a(16'd0), "a_post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adc_uart_reporter.md
Name: adc_uart_reporter

Overview:
Parametrised successor to the ADC0809-to-UART path. Accepts a multi-channel ADC sample vector with a valid strobe and averages 2^AVG_LOG2 samples per channel. At a fixed report rate it emits a framed, checksummed packet of the enabled channels as a byte stream. The byte stream feeds the existing UART transmitter through a valid/ready handshake. The block sits between the ADC driver and the UART TX byte engine.

Parameters:
CH_NUM, 8, number of ADC channels (1..8)
DATA_W, 8, bits per sample (8..16); values above 8 are sent as two bytes
AVG_LOG2, 0, log2 of the number of samples averaged per channel (0..4)
TICK_DIV, 25_000_000, clk cycles per report tick (50 MHz / 2 Hz); benches override it with small values
HDR_BYTE, 8'hA5, frame header byte

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
sample_valid  in  1  one-cycle strobe: sample_data holds a complete channel set
sample_data  in  CH_NUM*DATA_W  channel k in bits [k*DATA_W +: DATA_W]
ch_mask  in  CH_NUM  channel enable; sampled at frame start
tx_data  out  8  byte to the UART TX
tx_valid  out  1  tx_data is valid
tx_ready  in  1  UART TX accepts the byte when valid&ready
frame_busy  out  1  a frame is in progress
overrun  out  1  sticky: a tick arrived while frame_busy was high; cleared only by rst

Behaviour:
- Reset (async assert, sync release): tx_data=0, tx_valid=0, frame_busy=0, overrun=0. Accumulators, average count, snapshot, snap_valid and tick counter are all cleared. FSM returns to IDLE.
- Accumulation: one accumulator per channel, DATA_W+AVG_LOG2 bits wide, no overflow possible.
  - Each sample_valid adds the sample to its accumulator and increments avg_cnt.
  - When avg_cnt reaches 2^AVG_LOG2, snapshot[k] = (acc[k] + sample[k]) >> AVG_LOG2 (truncating). Accumulators and avg_cnt are cleared in the same cycle and snap_valid is set.
  - With AVG_LOG2=0, each valid sample goes straight to the snapshot.
  - Accumulation continues during frames. The snapshot may update mid-frame, but the frame uses its own copy.
- Tick: a counter runs 0..TICK_DIV-1 and asserts tick for one cycle at the wrap.
  - Tick while IDLE and snap_valid=1: copy snapshot and ch_mask into the frame buffer, then enter HDR.
  - Tick while IDLE and snap_valid=0: ignored, no frame.
  - Tick while frame_busy=1: set overrun, drop the tick; the current frame is unaffected.
- Frame format: HDR_BYTE, mask byte (ch_mask zero-extended to 8 bits), then for each enabled channel in ascending index: [hi byte if DATA_W>8] lo byte, then CSUM.
  - Hi byte = sample[DATA_W-1:8] zero-extended.
  - CSUM = 8-bit modulo sum of every byte after the header, excluding CSUM itself.
- FSM states: IDLE -> HDR -> MASK -> [DATA_HI] -> DATA_LO -> (next enabled channel or CSUM) -> IDLE.
  - A state advances only on a tx_valid&tx_ready handshake.
  - While tx_valid=1 and tx_ready=0, tx_data stays stable and tx_valid stays high.
  - Throughput is one byte per cycle when tx_ready is held high.
  - tx_valid rises the cycle after the tick.
- frame_busy is 1 from the cycle after the accepting tick until the cycle after the CSUM handshake.
- Mask zero: the frame is A5 00 00.
- A simultaneous sample_valid and tick uses the snapshot as it stood before that cycle's update.
- rst asserted mid-frame: tx_valid drops immediately and the frame is abandoned, not resumed.

Optional Feature:
ADC_UART_SEQ_EN
- Defined: a 16-bit frame sequence counter, reset to 0, is inserted after the mask byte as two bytes, MSB first. The sequence bytes are included in CSUM. The counter increments after each completed CSUM handshake and wraps 0xFFFF->0x0000.
- Undefined: no sequence bytes and no counter logic; the frame is exactly as described above.

Test Plan:
- CH_NUM=8, DATA_W=8, AVG_LOG2=0, TICK_DIV=200, tx_ready=1, ch_mask=0x05, ch0=0x12, ch2=0x34 -> bytes A5 05 12 34 4B, then frame_busy=0.
- AVG_LOG2=2, ch0 fed 10,11,12,13, mask=0x01 -> data byte 0x0B, CSUM 0x0C; fewer than 4 samples before the first tick -> no frame.
- DATA_W=10, mask=0x01, ch0=0x3FF -> A5 01 03 FF 03.
- tx_ready low for 5 cycles on the MASK byte -> tx_valid=1 and tx_data=0x05 held stable, byte sent once ready rises; no byte lost or duplicated.
- tx_ready held low across the next tick -> overrun=1 and stays 1; only one frame is emitted once ready is restored; the next tick then starts a new frame.
- rst pulsed on the third byte -> tx_valid=0 and overrun=0 the same cycle; the first post-reset frame starts fresh with A5. With ADC_UART_SEQ_EN, the sequence bytes of that frame are 00 00.
